// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared types and operand/destination codes for the configurable PE
package pe_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_DIV  = 3'd3,
    OP_PASS = 3'd4,
    OP_AND  = 3'd5,
    OP_OR   = 3'd6,
    OP_XOR  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_DIVIDE = 2'd2
  } state_e;

  localparam logic [3:0] CODE_E    = 4'd0;
  localparam logic [3:0] CODE_S    = 4'd1;
  localparam logic [3:0] CODE_W    = 4'd2;
  localparam logic [3:0] CODE_N    = 4'd3;
  localparam logic [3:0] CODE_DMEM = 4'd4;
  localparam logic [3:0] CODE_REG  = 4'd8;

  typedef struct packed {
    logic [3:0] dst;
    logic [3:0] src1;
    logic [3:0] src2;
    op_e        op;
  } pe_instr_t;

  function automatic logic is_port(input logic [3:0] code);
    return code < 4'd4;
  endfunction

endpackage

// File: rtl/pe_divider.sv
// rtl/pe_divider.sv - restoring unsigned divider, one quotient bit per cycle
module pe_divider #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go_i,
  input  logic [DW-1:0] dividend_i,
  input  logic [DW-1:0] divisor_i,
  output logic          done_o,
  output logic [DW-1:0] quotient_o
);

  localparam int CW = $clog2(DW + 1);

  logic [DW-1:0] rem_q, quo_q, den_q;
  logic [CW-1:0] cnt_q;
  logic [DW:0]   trial, diff;
  logic          fits;
  logic [DW-1:0] rem_d, quo_d;

  // quotient_o is the post-step value so the top can commit it on the final cycle
  always_comb begin
    trial = {rem_q, quo_q[DW-1]};
    diff  = trial - {1'b0, den_q};
    fits  = trial >= {1'b0, den_q};
    rem_d = fits ? diff[DW-1:0] : trial[DW-1:0];
    quo_d = {quo_q[DW-2:0], fits};
  end

  assign done_o     = (cnt_q == CW'(1));
  assign quotient_o = quo_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      den_q <= '0;
      cnt_q <= '0;
    end else if (go_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      den_q <= divisor_i;
      cnt_q <= CW'(DW);
    end else if (cnt_q != '0) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/pe_cfg.sv
// rtl/pe_cfg.sv - programmable processing element stepping through a looping local config memory
module pe_cfg
  import pe_pkg::*;
#(
  parameter int DW   = 16,
  parameter int NREG = 4,
  parameter int NCFG = 8,
  parameter int AW   = $clog2(NCFG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [14:0]   cfg_data,
  input  logic [AW-1:0] cfg_last,
  input  logic          start,
  input  logic          stop,
  input  logic [DW-1:0] in_e,
  input  logic [DW-1:0] in_s,
  input  logic [DW-1:0] in_w,
  input  logic [DW-1:0] in_n,
  input  logic [3:0]    in_valid,
  output logic [DW-1:0] out_e,
  output logic [DW-1:0] out_s,
  output logic [DW-1:0] out_w,
  output logic [DW-1:0] out_n,
  output logic [3:0]    out_valid,
  output logic [DW-1:0] dmem_data,
  output logic          dmem_valid,
  output logic          busy,
  output logic [AW-1:0] pc
);

  pe_instr_t     mem_q [NCFG];
  state_e        state_q;
  logic [AW-1:0] pc_q, last_q, pc_d;
  logic          stop_q, stop_pend;
  logic [DW-1:0] regs_q [8];
  logic [DW-1:0] out_q [4];
  logic [3:0]    out_valid_q;
  logic [DW-1:0] dmem_q;
  logic          dmem_valid_q;

  logic [DW-1:0]   nb [4];
  pe_instr_t       instr;
  logic [DW-1:0]   a, b, alu, div_res, wr_val;
  logic [2*DW-1:0] prod;
  logic            a_ok, b_ok, issue, div_go, div_done, wr_en;

  assign nb[0] = in_e;
  assign nb[1] = in_s;
  assign nb[2] = in_w;
  assign nb[3] = in_n;

  // Config memory is deliberately outside the reset domain so programs survive rst.
  always_ff @(posedge clk) begin
    if (cfg_we && state_q == ST_IDLE) mem_q[cfg_addr] <= pe_instr_t'(cfg_data);
  end

  function automatic logic [DW-1:0] src_val(input logic [3:0] c);
    src_val = '0;
    if (is_port(c)) src_val = nb[c[1:0]];
    else if (c[3] && int'(c[2:0]) < NREG) src_val = regs_q[c[2:0]];
  endfunction

  always_comb begin
    instr     = mem_q[pc_q];
    a         = src_val(instr.src1);
    b         = src_val(instr.src2);
    a_ok      = !is_port(instr.src1) || in_valid[instr.src1[1:0]];
    b_ok      = instr.op == OP_PASS || !is_port(instr.src2) || in_valid[instr.src2[1:0]];
    issue     = state_q == ST_EXEC && a_ok && b_ok;
    div_go    = issue && instr.op == OP_DIV;
    prod      = a * b;
    alu       = '0;
    case (instr.op)
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = a - b;
      OP_MUL:  alu = prod[DW-1:0];
      OP_PASS: alu = a;
      OP_AND:  alu = a & b;
      OP_OR:   alu = a | b;
      OP_XOR:  alu = a ^ b;
      default: alu = '0;
    endcase
    wr_en     = (issue && instr.op != OP_DIV) || (state_q == ST_DIVIDE && div_done);
    wr_val    = (state_q == ST_DIVIDE) ? div_res : alu;
    pc_d      = (pc_q == last_q) ? '0 : pc_q + AW'(1);
    stop_pend = stop_q || stop;
  end

  pe_divider #(.DW(DW)) u_div (
    .clk        (clk),
    .rst        (rst),
    .go_i       (div_go),
    .dividend_i (a),
    .divisor_i  (b),
    .done_o     (div_done),
    .quotient_o (div_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      last_q       <= '0;
      stop_q       <= 1'b0;
      out_valid_q  <= '0;
      dmem_q       <= '0;
      dmem_valid_q <= 1'b0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      for (int i = 0; i < 4; i++) out_q[i] <= '0;
    end else begin
      out_valid_q  <= '0;
      dmem_valid_q <= 1'b0;
      if (stop && state_q != ST_IDLE) stop_q <= 1'b1;
      if (wr_en) begin
        if (is_port(instr.dst)) begin
          out_q[instr.dst[1:0]]       <= wr_val;
          out_valid_q[instr.dst[1:0]] <= 1'b1;
        end else if (instr.dst == CODE_DMEM) begin
          dmem_q       <= wr_val;
          dmem_valid_q <= 1'b1;
        end else if (instr.dst[3] && int'(instr.dst[2:0]) < NREG) begin
          regs_q[instr.dst[2:0]] <= wr_val;
        end
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            last_q  <= cfg_last;
            pc_q    <= '0;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (issue && instr.op == OP_DIV) begin
            state_q <= ST_DIVIDE;
          end else begin
            if (issue) pc_q <= pc_d;
            if (stop_pend) begin
              state_q <= ST_IDLE;
              stop_q  <= 1'b0;
            end
          end
        end
        ST_DIVIDE: begin
          if (div_done) begin
            pc_q    <= pc_d;
            state_q <= stop_pend ? ST_IDLE : ST_EXEC;
            if (stop_pend) stop_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_e      = out_q[0];
  assign out_s      = out_q[1];
  assign out_w      = out_q[2];
  assign out_n      = out_q[3];
  assign out_valid  = out_valid_q;
  assign dmem_data  = dmem_q;
  assign dmem_valid = dmem_valid_q;
  assign busy       = state_q != ST_IDLE;
  assign pc         = pc_q;

endmodule

// File: tb/tb_pe_cfg.sv
// tb/tb_pe_cfg.sv - directed scoreboard bench for pe_cfg
module tb_pe_cfg;

  localparam int DW   = 16;
  localparam int NREG = 4;
  localparam int NCFG = 8;
  localparam int AW   = 3;

  logic          clk = 1'b0;
  logic          rst, cfg_we, start, stop;
  logic [AW-1:0] cfg_addr, cfg_last, pc;
  logic [14:0]   cfg_data;
  logic [DW-1:0] in_e, in_s, in_w, in_n;
  logic [3:0]    in_valid, out_valid;
  logic [DW-1:0] out_e, out_s, out_w, out_n, dmem_data;
  logic          dmem_valid, busy;

  always #5 clk = ~clk;

  pe_cfg #(.DW(DW), .NREG(NREG), .NCFG(NCFG)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_last(cfg_last), .start(start), .stop(stop),
    .in_e(in_e), .in_s(in_s), .in_w(in_w), .in_n(in_n), .in_valid(in_valid),
    .out_e(out_e), .out_s(out_s), .out_w(out_w), .out_n(out_n), .out_valid(out_valid),
    .dmem_data(dmem_data), .dmem_valid(dmem_valid), .busy(busy), .pc(pc)
  );

  typedef struct packed {
    logic [3:0]    vmask;
    logic          dm;
    logic [DW-1:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic expect_pulse(input logic [3:0] vmask, input logic dm, input logic [DW-1:0] val);
    exp_q.push_back('{vmask, dm, val});
  endtask

  task automatic check_pulse(input string tag);
    exp_t          e;
    logic [DW-1:0] obs;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, " valid"}, {27'd0, out_valid, dmem_valid}, {27'd0, e.vmask, e.dm});
    if (e.dm)            obs = dmem_data;
    else if (e.vmask[0]) obs = out_e;
    else if (e.vmask[1]) obs = out_s;
    else if (e.vmask[2]) obs = out_w;
    else                 obs = out_n;
    chk({tag, " data"}, obs, e.val);
  endtask

  task automatic no_pulse(input string tag);
    chk(tag, {27'd0, out_valid, dmem_valid}, 32'd0);
  endtask

  task automatic wr_cfg(input logic [AW-1:0] addr, input logic [3:0] d, input logic [3:0] s1,
                        input logic [3:0] s2, input logic [2:0] op);
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_data = {d, s1, s2, op};
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic do_start(input logic [AW-1:0] last);
    cfg_last = last;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Single DIV in slot 0 (E <= W / S) with stop raised during DIVIDE.
  task automatic run_div(input string tag, input logic [DW-1:0] w, input logic [DW-1:0] s,
                         input logic [DW-1:0] q);
    in_w     = w;
    in_s     = s;
    in_valid = 4'b0110;
    do_start(0);
    expect_pulse(4'b0001, 1'b0, q);
    tick();
    stop = 1'b1;
    no_pulse({tag, " early"});
    tick();
    stop = 1'b0;
    for (int k = 2; k <= DW; k++) begin
      no_pulse({tag, " early"});
      if (k < DW) tick();
    end
    chk({tag, " busy before"}, busy, 1);
    tick();
    check_pulse(tag);
    chk({tag, " busy after"}, busy, 0);
    tick();
    no_pulse({tag, " after idle"});
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_last = '0;
    start = 1'b0; stop = 1'b0;
    in_e = '0; in_s = '0; in_w = '0; in_n = '0; in_valid = '0;
    tick(); tick();
    chk("rst out_e", out_e, 0);
    chk("rst out_n", out_n, 0);
    chk("rst dmem", dmem_data, 0);
    chk("rst valid", {out_valid, dmem_valid}, 0);
    chk("rst busy", busy, 0);
    chk("rst pc", pc, 0);
    rst = 1'b0;
    tick();

    // ADD: E <= W + S, back-to-back every cycle
    wr_cfg(0, 4'd0, 4'd2, 4'd1, 3'd0);
    in_w = 16'd5; in_s = 16'd7; in_valid = 4'b0110;
    do_start(0);
    chk("add busy rise", busy, 1);
    for (int i = 0; i < 4; i++) begin
      expect_pulse(4'b0001, 1'b0, 16'd12);
      tick();
      check_pulse("add");
    end
    stop = 1'b1;
    expect_pulse(4'b0001, 1'b0, 16'd12);
    tick();
    stop = 1'b0;
    check_pulse("add stop");
    chk("add busy fall", busy, 0);
    tick();
    no_pulse("add idle");

    // DIV latency, normal and divide-by-zero
    wr_cfg(0, 4'd0, 4'd2, 4'd1, 3'd3);
    run_div("div", 16'd100, 16'd7, 16'd14);
    run_div("div0", 16'd100, 16'd0, 16'hFFFF);

    // SUB to reg0 then MUL reg0*reg0 to dmem, pc wraps 1 -> 0
    wr_cfg(0, 4'd8, 4'd2, 4'd1, 3'd1);
    wr_cfg(1, 4'd4, 4'd8, 4'd8, 3'd2);
    in_w = 16'd3; in_s = 16'd5; in_valid = 4'b0110;
    do_start(1);
    chk("sm pc0", pc, 0);
    tick();
    no_pulse("sm sub");
    chk("sm pc1", pc, 1);
    expect_pulse(4'b0000, 1'b1, 16'h0004);
    tick();
    check_pulse("sm mul");
    chk("sm pc wrap", pc, 0);
    tick();
    no_pulse("sm sub2");
    stop = 1'b1;
    expect_pulse(4'b0000, 1'b1, 16'h0004);
    tick();
    stop = 1'b0;
    check_pulse("sm mul2");
    chk("sm busy", busy, 0);

    // reg0 read back through N with PASS
    wr_cfg(0, 4'd3, 4'd8, 4'd0, 3'd4);
    do_start(0);
    expect_pulse(4'b1000, 1'b0, 16'hFFFE);
    tick();
    check_pulse("reg0");
    stop = 1'b1;
    expect_pulse(4'b1000, 1'b0, 16'hFFFE);
    tick();
    stop = 1'b0;
    check_pulse("reg0 stop");

    // stall on N not valid
    wr_cfg(0, 4'd0, 4'd3, 4'd3, 3'd4);
    in_n = 16'h1234; in_valid = 4'b0000;
    do_start(0);
    for (int i = 0; i < 5; i++) begin
      tick();
      no_pulse("stall valid");
      chk("stall pc", pc, 0);
    end
    in_valid = 4'b1000;
    expect_pulse(4'b0001, 1'b0, 16'h1234);
    tick();
    check_pulse("stall release");
    in_valid = 4'b0000;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    no_pulse("stall stop valid");
    chk("stall stop busy", busy, 0);

    // reset mid-DIVIDE, then re-start on surviving config
    wr_cfg(0, 4'd0, 4'd2, 4'd1, 3'd3);
    in_w = 16'd100; in_s = 16'd7; in_valid = 4'b0110;
    do_start(0);
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("mid rst out_e", out_e, 0);
    chk("mid rst dmem", dmem_data, 0);
    chk("mid rst busy", busy, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < DW + 2; i++) begin
      tick();
      no_pulse("mid rst no write");
    end
    chk("mid rst out_e hold", out_e, 0);
    run_div("div after rst", 16'd100, 16'd7, 16'd14);

    chk("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
